// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and defaults for the multiply/divide unit.
//   md_op_t    - op encoding on the EX-stage op bus (6/7 are no-ops)
//   md_state_t - FSM state of mdu_pipe
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // True for ops that occupy the unit for a multi-cycle latency.
  function automatic logic isLongOp(md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_pipe_if.sv
// mdu_pipe_if: EX-stage <-> multiply/divide unit bundle.
//   master (EX stage): drives start, op, a, b, flush; sees busy, done, hi, lo
//   slave  (mdu_pipe): the reverse
interface mdu_pipe_if #(parameter int WIDTH = 32);
  import mdu_pkg::*;

  logic             start;
  md_op_t           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_calc.sv
// mdu_calc: combinational multiply/divide result generator.
//   op        - md_op_t operation
//   a, b      - rs / rt operands
//   resHi/Lo  - HI/LO result (mult: product halves; div: remainder/quotient)
// Divide by zero yields lo=all-ones, hi=a. Signed MIN/-1 yields lo=MIN, hi=0.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] resHi,
  output logic [WIDTH-1:0] resLo
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] prod;

  always_comb begin
    prod  = '0;
    resHi = '0;
    resLo = '0;
    case (op)
      MD_MULT: begin
        prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        {resHi, resLo} = prod;
      end
      MD_MULTU: begin
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        {resHi, resLo} = prod;
      end
      MD_DIV: begin
        // Guard the two cases a plain signed divider leaves undefined.
        if (b == '0) begin
          resLo = '1;
          resHi = a;
        end else if (a == MIN_VAL && b == '1) begin
          resLo = MIN_VAL;
          resHi = '0;
        end else begin
          resLo = $signed(a) / $signed(b);
          resHi = $signed(a) % $signed(b);
        end
      end
      MD_DIVU: begin
        if (b == '0) begin
          resLo = '1;
          resHi = a;
        end else begin
          resLo = a / b;
          resHi = a % b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_pipe.sv
// mdu_pipe: multi-cycle multiply/divide unit with architectural HI/LO.
//   clk, reset - clock, async active-high reset
//   bus        - mdu_pipe_if.slave: start/op/a/b/flush in; busy/done/hi/lo out
// The result is computed at the start edge and held in pendHi/pendLo; the
// counter only models latency. HI/LO commit at edge T+LAT, done follows.
// Hazard unit stalls RR-stage MD instructions on (busy | start_in_EX).
module mdu_pipe
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  // Must also be wide enough for MULT_CYCLES.
  parameter int CNT_W       = $clog2(DIV_CYCLES + 1)
) (
  input logic       clk,
  input logic       reset,
  mdu_pipe_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pendHi, pendLo, hiQ, loQ;
  logic [WIDTH-1:0] calcHi, calcLo;
  logic             busyQ, doneQ;

  mdu_calc #(.WIDTH(WIDTH)) uCalc (
    .op    (bus.op),
    .a     (bus.a),
    .b     (bus.b),
    .resHi (calcHi),
    .resLo (calcLo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      pendHi <= '0;
      pendLo <= '0;
      hiQ    <= '0;
      loQ    <= '0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      case (state)
        ST_IDLE: begin
          // flush also kills a same-edge start, MTHI/MTLO included
          if (bus.start && !bus.flush) begin
            if (isLongOp(bus.op)) begin
              pendHi <= calcHi;
              pendLo <= calcLo;
              cnt    <= (bus.op == MD_DIV || bus.op == MD_DIVU) ? DIV_LAT : MULT_LAT;
              busyQ  <= 1'b1;
              state  <= ST_RUN;
            end else if (bus.op == MD_MTHI) begin
              hiQ <= bus.a;
            end else if (bus.op == MD_MTLO) begin
              loQ <= bus.a;
            end
          end
        end
        ST_RUN: begin
          // start is ignored here; flush wins over the final commit
          if (bus.flush) begin
            cnt   <= '0;
            busyQ <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt == CNT_W'(1)) begin
            hiQ   <= pendHi;
            loQ   <= pendLo;
            cnt   <= '0;
            busyQ <= 1'b0;
            doneQ <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busyQ;
  assign bus.done = doneQ;
  assign bus.hi   = hiQ;
  assign bus.lo   = loQ;

endmodule

// File: doc/mdu_pipe.md
Name: mdu_pipe

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the EX stage of the 5-stage core.
- Accepts one operation per start pulse and models a configurable latency.
- Exports busy so the hazard unit can stall MD-class instructions (MULT/DIV/MFHI/MFLO/MTHI/MTLO) in RR.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles busy after a MULT/MULTU start (>=1).
- DIV_CYCLES, 10, cycles busy after a DIV/DIVU start (>=1).
- CNT_W, $clog2(DIV_CYCLES+1), busy counter width; must also hold MULT_CYCLES.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  EX-stage instruction is an MD op; sampled at posedge.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 are no-op.
- a  in  WIDTH  rs value, already forwarded.
- b  in  WIDTH  rt value, already forwarded.
- flush  in  1  cancel an in-flight op; HI/LO keep their pre-op values.
- busy  out  1  op in flight.
- done  out  1  one-cycle pulse in the cycle after HI/LO commit.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and reset.
- Reset values: state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, pending registers 0. Reset takes effect immediately, including mid-operation.
- FSM has two states, IDLE and RUN.
- IDLE, start with op MULT/MULTU/DIV/DIVU:
  - latch the result into pend_hi/pend_lo, computed combinationally from a/b at this edge;
  - load cnt = LAT (MULT_CYCLES or DIV_CYCLES);
  - go to RUN.
- IDLE, start with op MTHI/MTLO: write hi (or lo) = a at that edge; stay IDLE; busy stays 0; no done pulse.
- IDLE, start with op 6/7: ignored.
- RUN:
  - busy=1 for exactly LAT cycles after the start edge;
  - cnt decrements each edge;
  - on the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, go to IDLE, done<=1 for one cycle.
- Latency: start sampled at edge T → busy high over [T, T+LAT) → hi/lo new from edge T+LAT.
- Start while RUN: ignored (no effect on state or pending result). The hazard unit guarantees this never happens; the bench asserts it.
- flush:
  - In RUN: return to IDLE at that edge; hi/lo unchanged; no done. Flush beats the final commit if both occur on the same edge.
  - In IDLE: flush also suppresses a same-edge start, including MTHI/MTLO.
- MULT: signed 2*WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits.
- MULTU: same split, unsigned product.
- DIV, signed:
  - quotient truncates toward zero; remainder takes the dividend's sign;
  - lo = quotient, hi = remainder;
  - overflow case a=MIN, b=-1: lo=MIN, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV and DIVU): lo = all-ones, hi = a.
- Stall contract for the hazard unit: stall an RR-stage MD instruction when (busy | start_in_EX).

Decomposition:
- Shared package mdu_pkg holds:
  - enum md_op_t encoding the op values above;
  - typedef for the FSM state;
  - constants MD_MULT_CYCLES_DEF=5 and MD_DIV_CYCLES_DEF=10.
- One natural sub-module, mdu_calc: purely combinational; maps op/a/b to res_hi/res_lo, including the signed, overflow and divide-by-zero rules.
- mdu_pipe keeps the FSM, counter, pending registers and HI/LO.

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=7, default params → busy high for 5 cycles; at T+5 hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE; DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy lasts exactly 10 cycles.
- DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0; DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5.
- MTHI a=0x1234 then MTLO a=0x5678 in consecutive idle cycles → hi=0x1234 and lo=0x5678 one edge each; busy never asserts.
- DIV start, flush at cycle 4 → busy drops at that edge; hi/lo keep prior values; no done. A start held during RUN leaves the result unchanged.
- Reset asserted asynchronously mid-MULT (cycle 2) → busy, hi, lo and done read 0 before the next clock edge; a new MULT after release completes normally.
- Parameter sweep MULT_CYCLES=1, DIV_CYCLES=1 → busy high for one cycle, result at T+1.
